// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - 8N1 UART transmitter fed from a show-ahead FIFO, mode-selected baud.
// Optional even/odd parity bit when UART_TX_PARITY_EN is defined.
module uart_tx_engine #(
  parameter int CLK_FREQ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  input  logic [3:0] mode,
`ifdef UART_TX_PARITY_EN
  input  logic [1:0] parity_mode,
`endif
  output logic       tx_line,
  output logic       busy
);

  function automatic int baud_div(input int baud);
    return (CLK_FREQ + baud / 2) / baud;
  endfunction

  localparam int DIV_MAX = baud_div(4800);
  localparam int CW      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  typedef logic [CW-1:0] cnt_t;

  // Terminal count (DIV-1) per mode code, fixed at elaboration.
  localparam cnt_t LAST_4800   = cnt_t'(baud_div(4800) - 1);
  localparam cnt_t LAST_9600   = cnt_t'(baud_div(9600) - 1);
  localparam cnt_t LAST_19200  = cnt_t'(baud_div(19200) - 1);
  localparam cnt_t LAST_38400  = cnt_t'(baud_div(38400) - 1);
  localparam cnt_t LAST_57600  = cnt_t'(baud_div(57600) - 1);
  localparam cnt_t LAST_115200 = cnt_t'(baud_div(115200) - 1);
  localparam cnt_t LAST_230400 = cnt_t'(baud_div(230400) - 1);
  localparam cnt_t LAST_460800 = cnt_t'(baud_div(460800) - 1);
  localparam cnt_t LAST_921600 = cnt_t'(baud_div(921600) - 1);

  function automatic cnt_t last_count(input logic [3:0] code);
    case (code)
      4'd0:    return LAST_4800;
      4'd1:    return LAST_9600;
      4'd2:    return LAST_19200;
      4'd3:    return LAST_38400;
      4'd4:    return LAST_57600;
      4'd5:    return LAST_115200;
      4'd6:    return LAST_230400;
      4'd7:    return LAST_460800;
      4'd8:    return LAST_921600;
      default: return LAST_9600;
    endcase
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  cnt_t       baud_cnt_q, baud_cnt_d;
  logic [3:0] mode_q, mode_d;
  logic       ready_q, ready_d;
  logic       tx_q, tx_d;
  logic       bit_done;
`ifdef UART_TX_PARITY_EN
  logic       par_en_q, par_en_d;
  logic       par_bit_q, par_bit_d;
`endif

  assign bit_done = (baud_cnt_q == last_count(mode_q));

  // tx_d is derived from the next state so the line is driven straight from a flop.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = baud_cnt_q + cnt_t'(1);
    mode_d     = mode_q;
    ready_d    = 1'b0;
    tx_d       = tx_q;
`ifdef UART_TX_PARITY_EN
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
`endif
    case (state_q)
      S_IDLE: begin
        tx_d       = 1'b1;
        baud_cnt_d = '0;
        if (data_valid) begin
          shift_d   = data_in;
          mode_d    = mode;
          bit_cnt_d = 3'd0;
          ready_d   = 1'b1;
          tx_d      = 1'b0;
          state_d   = S_START;
`ifdef UART_TX_PARITY_EN
          par_en_d  = ^parity_mode;
          par_bit_d = (^data_in) ^ parity_mode[1];
`endif
        end
      end
      S_START: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          tx_d       = shift_q[0];
          state_d    = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift_q[7:1]};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              tx_d    = par_bit_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          tx_d       = 1'b1;
          state_d    = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          tx_d       = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: begin
        baud_cnt_d = '0;
        tx_d       = 1'b1;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      baud_cnt_q <= '0;
      mode_q     <= '0;
      ready_q    <= 1'b0;
      tx_q       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_cnt_q <= baud_cnt_d;
      mode_q     <= mode_d;
      ready_q    <= ready_d;
      tx_q       <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
`endif
    end
  end

  assign data_ready = ready_q;
  assign tx_line    = tx_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb/tb_uart_tx_engine.sv - scoreboard bench: FIFO model, bit-exact frame monitor, 50 MHz divisor checks.
// Parity vectors are added when UART_TX_PARITY_EN is defined.
module tb_uart_tx_engine;

  typedef struct {
    logic [7:0] data;
    logic [3:0] mode;
    int         div;
    logic [1:0] pm;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    int         div;
    logic       par_en;
    logic       par;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic [3:0] mode;
  logic       tx_line;
  logic       busy;
`ifdef UART_TX_PARITY_EN
  logic [1:0] parity_mode;
  logic [1:0] parity_mode50;
`endif

  logic       rst50;
  logic [7:0] din50;
  logic       dv50;
  logic       ready50;
  logic [3:0] mode50;
  logic       tx50;
  logic       busy50;

  int checks;
  int fails;
  int ready_cnt;
  int aborts;
  int cyc;
  logic mon_active;

  logic [7:0] fifo[$];
  exp_t       sb[$];
  int         frame_start_q[$];
  vec_t       vecs[$];

  uart_tx_engine #(.CLK_FREQ(1000000)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .mode       (mode),
`ifdef UART_TX_PARITY_EN
    .parity_mode(parity_mode),
`endif
    .tx_line    (tx_line),
    .busy       (busy)
  );

  uart_tx_engine dut50 (
    .clk        (clk),
    .rst        (rst50),
    .data_in    (din50),
    .data_valid (dv50),
    .data_ready (ready50),
    .mode       (mode50),
`ifdef UART_TX_PARITY_EN
    .parity_mode(parity_mode50),
`endif
    .tx_line    (tx50),
    .busy       (busy50)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Show-ahead FIFO: pops on data_ready, head always presented on data_in.
  initial begin
    data_valid = 1'b0;
    data_in    = 8'h00;
    forever begin
      @(negedge clk);
      if (data_ready === 1'b1) begin
        ready_cnt++;
        if (fifo.size() > 0) void'(fifo.pop_front());
      end
      data_valid = (fifo.size() > 0);
      data_in    = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end
  end

  // Frame monitor: each frame is checked cycle-by-cycle against the popped expectation.
  initial begin
    exp_t e;
    logic bits [0:10];
    int   nb;
    int   bad;
    logic aborted;
    mon_active = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx_line === 1'b0 && !mon_active) begin
        mon_active = 1'b1;
        frame_start_q.push_back(cyc);
        checks++;
        if (data_ready !== 1'b1)
          $display("FAIL ready_at_start: data_ready=%b required 1", data_ready);
        if (data_ready !== 1'b1) fails++;
        if (sb.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_frame at cycle %0d: no byte expected", cyc);
        end else begin
          e = sb.pop_front();
          bits[0] = 1'b0;
          for (int k = 0; k < 8; k++) bits[k+1] = e.data[k];
          bits[9]  = e.par_en ? e.par : 1'b1;
          bits[10] = 1'b1;
          nb = e.par_en ? 11 : 10;
          aborted = 1'b0;
          for (int b = 0; b < nb && !aborted; b++) begin
            bad = 0;
            for (int c = 0; c < e.div && !aborted; c++) begin
              if (b != 0 || c != 0) @(negedge clk);
              if (rst === 1'b1) aborted = 1'b1;
              else if (tx_line !== bits[b] || busy !== 1'b1 ||
                       data_ready !== ((b == 0 && c == 0) ? 1'b1 : 1'b0)) bad++;
            end
            if (!aborted) begin
              checks++;
              if (bad != 0) begin
                fails++;
                $display("FAIL frame_bit byte=%h bit=%0d: %0d bad cycles of %0d, required level %b",
                         e.data, b, bad, e.div, bits[b]);
              end
            end
          end
          if (aborted) aborts++;
          else begin
            @(negedge clk);
            checks++;
            if (tx_line !== 1'b1 || busy !== 1'b0) begin
              fails++;
              $display("FAIL idle_gap byte=%h: tx_line=%b busy=%b required 1/0", e.data, tx_line, busy);
            end
          end
        end
        mon_active = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] d, input int div, input logic [1:0] pm);
    exp_t e;
    e.data = d;
    e.div  = div;
`ifdef UART_TX_PARITY_EN
    e.par_en = (pm == 2'b01) || (pm == 2'b10);
`else
    e.par_en = 1'b0;
`endif
    e.par = (^d) ^ (pm == 2'b10);
    fifo.push_back(d);
    sb.push_back(e);
  endtask

  task automatic run_until_done(input int budget, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!(fifo.size() == 0 && sb.size() == 0 && !mon_active && busy === 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++;
      fails++;
      $display("FAIL timeout %s: still busy after %0d cycles, required idle", nm, budget);
    end
    step();
  endtask

  task automatic wait_ready(input int r0, input int budget, input string nm);
    int n;
    n = 0;
    while (ready_cnt == r0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (ready_cnt == r0) begin
      fails++;
      $display("FAIL %s: no data_ready within %0d cycles", nm, budget);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic start_len50(input logic [3:0] m, input int req, input string nm);
    int n;
    int cnt;
    @(negedge clk);
    rst50 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst50  = 1'b0;
    mode50 = m;
    din50  = 8'h55;
    dv50   = 1'b1;
    n = 0;
    @(negedge clk);
    while (ready50 !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    dv50 = 1'b0;
    cnt = 0;
    while (tx50 === 1'b0 && cnt < 6000) begin
      cnt++;
      @(negedge clk);
    end
    check_int(nm, cnt, req);
  endtask

  initial begin
    int r0;
    int n0;
    int bad;
    checks = 0; fails = 0; ready_cnt = 0; aborts = 0;
    rst = 1'b1; mode = 4'd0;
    rst50 = 1'b1; din50 = 8'h00; dv50 = 1'b0; mode50 = 4'd0;
`ifdef UART_TX_PARITY_EN
    parity_mode = 2'b00;
    parity_mode50 = 2'b00;
`endif

    vecs.push_back('{8'h55, 4'd1, 104, 2'b00});
    vecs.push_back('{8'hA5, 4'd5, 9,   2'b00});
    vecs.push_back('{8'h00, 4'hF, 104, 2'b00});
    vecs.push_back('{8'hFF, 4'd8, 1,   2'b00});
    vecs.push_back('{8'h81, 4'd7, 2,   2'b00});
    vecs.push_back('{8'hC3, 4'd6, 4,   2'b00});
    vecs.push_back('{8'h12, 4'd0, 208, 2'b00});
    vecs.push_back('{8'h34, 4'd2, 52,  2'b00});
    vecs.push_back('{8'h56, 4'd3, 26,  2'b00});
    vecs.push_back('{8'h78, 4'd4, 17,  2'b00});
    vecs.push_back('{8'h9A, 4'd9, 104, 2'b00});
`ifdef UART_TX_PARITY_EN
    vecs.push_back('{8'h07, 4'd5, 9, 2'b01});
    vecs.push_back('{8'h07, 4'd5, 9, 2'b10});
    vecs.push_back('{8'h07, 4'd5, 9, 2'b11});
    vecs.push_back('{8'hB4, 4'd6, 4, 2'b10});
`endif

    repeat (3) @(posedge clk);
    #1;
    check_int("reset_tx_line", int'(tx_line), 1);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_data_ready", int'(data_ready), 0);
    #1;
    rst = 1'b0;

    bad = 0;
    repeat (40) begin
      step();
      if (tx_line !== 1'b1 || busy !== 1'b0 || data_ready !== 1'b0) bad++;
    end
    check_int("idle_no_data", bad, 0);

    foreach (vecs[i]) begin
      mode = vecs[i].mode;
`ifdef UART_TX_PARITY_EN
      parity_mode = vecs[i].pm;
`endif
      r0 = ready_cnt;
      n0 = frame_start_q.size();
      push(vecs[i].data, vecs[i].div, vecs[i].pm);
      run_until_done(12 * vecs[i].div + 40, "table");
      check_int("table_ready_pulses", ready_cnt - r0, 1);
      check_int("table_frames", frame_start_q.size() - n0, 1);
    end
`ifdef UART_TX_PARITY_EN
    parity_mode = 2'b00;
`endif

    mode = 4'd5;
    r0 = ready_cnt;
    n0 = frame_start_q.size();
    push(8'hA5, 9, 2'b00);
    push(8'h3C, 9, 2'b00);
    run_until_done(300, "back_to_back");
    check_int("b2b_ready_pulses", ready_cnt - r0, 2);
    check_int("b2b_frames", frame_start_q.size() - n0, 2);
    if (frame_start_q.size() - n0 == 2)
      check_int("b2b_spacing", frame_start_q[n0+1] - frame_start_q[n0], 91);

    mode = 4'd5;
    r0 = ready_cnt;
    n0 = frame_start_q.size();
    push(8'h5A, 9, 2'b00);
    push(8'hC3, 104, 2'b00);
    wait_ready(r0, 20, "mode_change_accept");
    repeat (20) step();
    mode = 4'd1;
    run_until_done(1500, "mode_change");
    check_int("mode_change_ready_pulses", ready_cnt - r0, 2);
    if (frame_start_q.size() - n0 == 2)
      check_int("mode_change_spacing", frame_start_q[n0+1] - frame_start_q[n0], 91);
    else
      check_int("mode_change_frames", frame_start_q.size() - n0, 2);

    mode = 4'd5;
    r0 = ready_cnt;
    push(8'hFF, 9, 2'b00);
    wait_ready(r0, 20, "reset_mid_accept");
    repeat (36) step();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_int("midreset_tx_line", int'(tx_line), 1);
    check_int("midreset_busy", int'(busy), 0);
    #1;
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      step();
      if (tx_line !== 1'b1 || busy !== 1'b0) bad++;
    end
    check_int("midreset_stays_idle", bad, 0);
    check_int("midreset_ready_pulses", ready_cnt - r0, 1);
    check_int("midreset_aborts", aborts, 1);
    r0 = ready_cnt;
    push(8'h3C, 9, 2'b00);
    run_until_done(300, "after_reset");
    check_int("after_reset_ready_pulses", ready_cnt - r0, 1);

    rst = 1'b1;
    r0 = ready_cnt;
    push(8'h96, 9, 2'b00);
    bad = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0 || data_ready !== 1'b0 || tx_line !== 1'b1) bad++;
      #1;
    end
    check_int("reset_beats_valid", bad, 0);
    check_int("reset_beats_valid_ready", ready_cnt - r0, 0);
    rst = 1'b0;
    run_until_done(300, "after_reset_valid");
    check_int("after_reset_valid_ready", ready_cnt - r0, 1);

    start_len50(4'd1, 5208, "clk50_mode1_start_len");
    start_len50(4'd5, 434, "clk50_mode5_start_len");
    start_len50(4'hF, 5208, "clk50_modeF_start_len");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
